// File: rtl/pwm_ramp_sequencer_if.sv
// Command inputs and PWM-side outputs of the duty-cycle ramp sequencer.
// The host/bench uses the master view and the sequencer uses the slave view.
interface pwm_ramp_sequencer_if #(
    parameter int COMPARE_SIZE  = 8,
    parameter int PRESCALE_SIZE = 16
);
    logic                     ena;
    logic                     load;
    logic [COMPARE_SIZE-1:0]  target_in;
    logic [COMPARE_SIZE-1:0]  step_in;
    logic [PRESCALE_SIZE-1:0] period_in;
    logic                     mode_in;
    logic [COMPARE_SIZE-1:0]  compare_out;
    logic                     wr;
    logic                     busy;
    logic                     done;

    modport master (
        output ena, load, target_in, step_in, period_in, mode_in,
        input  compare_out, wr, busy, done
    );

    modport slave (
        input  ena, load, target_in, step_in, period_in, mode_in,
        output compare_out, wr, busy, done
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Duty-cycle ramp generator feeding a PWM compare register: steps toward a target
// (one-shot) or bounces between 0 and the target (breathe), one step per prescaler wrap.
module pwm_ramp_sequencer #(
    parameter int COMPARE_SIZE  = 8,
    parameter int PRESCALE_SIZE = 16
) (
    input  logic                clk_in,
    input  logic                rst,
    pwm_ramp_sequencer_if.slave bus
);
    localparam int CW = COMPARE_SIZE;
    localparam int PW = PRESCALE_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cmp_q, cmp_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] step_q, step_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mode_q, mode_d;
    logic          pend_q, pend_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          breathe_s;
    logic          load_breathe_s;
    logic [CW-1:0] step_eff_s;
    logic [CW-1:0] floor_s;
    logic [CW:0]   sum_s;
    logic [CW:0]   diff_s;

    // Breathe with a zero target degenerates to a plain one-shot ramp.
    assign breathe_s      = mode_q && (tgt_q != {CW{1'b0}});
    assign load_breathe_s = bus.mode_in && (bus.target_in != {CW{1'b0}});
    assign step_eff_s     = (step_q == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : step_q;
    assign floor_s        = breathe_s ? {CW{1'b0}} : tgt_q;
    assign sum_s          = {1'b0, cmp_q} + {1'b0, step_eff_s};
    assign diff_s         = {1'b0, cmp_q} - {1'b0, step_eff_s};

    // Next-state logic: load capture, prescaler, clamped stepping and wr/done generation.
    always_comb begin
        state_d  = state_q;
        cmp_d    = cmp_q;
        tgt_d    = tgt_q;
        step_d   = step_q;
        period_d = period_q;
        presc_d  = presc_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        if (bus.ena) begin
            // A change recorded last cycle is strobed now, even if a load arrives.
            wr_d = pend_q;
            if (bus.load) begin
                tgt_d    = bus.target_in;
                step_d   = bus.step_in;
                period_d = bus.period_in;
                mode_d   = bus.mode_in;
                presc_d  = {PW{1'b0}};
                if (load_breathe_s) begin
                    state_d = (cmp_q < bus.target_in) ? ST_UP : ST_DOWN;
                end else if (bus.target_in > cmp_q) begin
                    state_d = ST_UP;
                end else if (bus.target_in < cmp_q) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_UP, ST_DOWN: begin
                        if (presc_q == period_q) begin
                            presc_d = {PW{1'b0}};
                            if (state_q == ST_UP) begin
                                if (sum_s >= {1'b0, tgt_q}) begin
                                    cmp_d   = tgt_q;
                                    state_d = breathe_s ? ST_DOWN : ST_IDLE;
                                    done_d  = ~breathe_s;
                                end else begin
                                    cmp_d = sum_s[CW-1:0];
                                end
                            end else begin
                                if (diff_s[CW] || (diff_s[CW-1:0] <= floor_s)) begin
                                    cmp_d   = floor_s;
                                    state_d = breathe_s ? ST_UP : ST_IDLE;
                                    done_d  = ~breathe_s;
                                end else begin
                                    cmp_d = diff_s[CW-1:0];
                                end
                            end
                        end else begin
                            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        presc_d = {PW{1'b0}};
                    end
                endcase
            end
            pend_d = (cmp_d != cmp_q);
        end else begin
            pend_d = pend_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmp_q    <= {CW{1'b0}};
            tgt_q    <= {CW{1'b0}};
            step_q   <= {CW{1'b0}};
            period_q <= {PW{1'b0}};
            presc_q  <= {PW{1'b0}};
            mode_q   <= 1'b0;
            pend_q   <= 1'b0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmp_q    <= cmp_d;
            tgt_q    <= tgt_d;
            step_q   <= step_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.compare_out = cmp_q;
    assign bus.wr          = wr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
